// File: rtl/jk_counter_bank.sv
`default_nettype none
// ============================================================================
// jk_counter_bank : WIDTH-bit JK flip-flop bank with hold/JK/up/down modes,
//                   clock enable, programmable modulus and registered wrap pulse
// Revision 1.0
// ============================================================================
module jk_counter_bank #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_COUNT   = 9,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qn_o,
  output logic             terminal_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_JK   = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] C_MAX   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] C_RESET = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] C_ZERO  = '0;
  localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q    <= C_RESET;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (en_i) begin
      case (w_mode)
        MODE_JK: q_d = (j_i & ~q_q) | (~k_i & q_q);
        MODE_UP: begin
          // Out-of-range values snap back to zero without signalling a wrap
          if (q_q < C_MAX) begin
            q_d = q_q + C_ONE;
          end else begin
            q_d    = C_ZERO;
            wrap_d = (q_q == C_MAX);
          end
        end
        MODE_DOWN: begin
          if (q_q == C_ZERO) begin
            q_d    = C_MAX;
            wrap_d = 1'b1;
          end else if (q_q > C_MAX) begin
            q_d = C_MAX;
          end else begin
            q_d = q_q - C_ONE;
          end
        end
        default: q_d = q_q;
      endcase
    end
  end

  assign q_o        = q_q;
  assign qn_o       = ~q_q;
  assign wrap_o     = wrap_q;
  assign terminal_o = ((w_mode == MODE_UP) && (q_q == C_MAX)) ||
                      ((w_mode == MODE_DOWN) && (q_q == C_ZERO));

endmodule
`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
`default_nettype none
// ============================================================================
// tb_jk_counter_bank : directed self-checking bench for jk_counter_bank
// Revision 1.0
// ============================================================================
module tb_jk_counter_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic [3:0] qn;
  logic       term;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  jk_counter_bank #(
    .WIDTH      (4),
    .MAX_COUNT  (9),
    .RESET_VALUE(0)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .mode_i    (mode),
    .j_i       (j),
    .k_i       (k),
    .q_o       (q),
    .qn_o      (qn),
    .terminal_o(term),
    .wrap_o    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    mode = 2'b00;
    j    = 4'h0;
    k    = 4'h0;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("rst_q", q, 4'h0);
    chk("rst_qn", qn, 4'hF);
    chk("rst_wrap", wrap, 1'b0);
    tick(1);
    rst  = 1'b0;
    en   = 1'b1;
    mode = 2'b10;
    tick(3);
    chk("post_rst_up3", q, 4'h3);

    // Reset mid-count aborts the count
    #2 rst = 1'b1;
    #1;
    chk("midcount_rst_q", q, 4'h0);
    chk("midcount_rst_wrap", wrap, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("after_rst_first", q, 4'h1);
    rst = 1'b1;
    #1 rst = 1'b0;

    // Up count 0..9 then wrap
    tick(9);
    chk("up9_q", q, 4'h9);
    chk("up9_term", term, 1'b1);
    chk("up9_wrap", wrap, 1'b0);
    tick(1);
    chk("up10_q", q, 4'h0);
    chk("up10_wrap", wrap, 1'b1);
    chk("up10_term", term, 1'b0);
    tick(1);
    chk("up11_q", q, 4'h1);
    chk("up11_wrap", wrap, 1'b0);

    // Down count from 1
    mode = 2'b11;
    chk("down_term_q1", term, 1'b0);
    tick(1);
    chk("down_q0", q, 4'h0);
    chk("down_term_q0", term, 1'b1);
    tick(1);
    chk("down_wrap_q", q, 4'h9);
    chk("down_wrap", wrap, 1'b1);
    tick(1);
    chk("down_q8", q, 4'h8);
    chk("down_q8_wrap", wrap, 1'b0);

    // JK mode: 1000 -> set bit1 -> 1010, then hold/set/clear/toggle
    mode = 2'b01;
    j    = 4'b0010;
    k    = 4'b0000;
    tick(1);
    chk("jk_load_a", q, 4'b1010);
    j = 4'b0101;
    k = 4'b0011;
    tick(1);
    chk("jk_q", q, 4'b1101);
    chk("jk_qn", qn, 4'b0010);
    chk("jk_wrap", wrap, 1'b0);
    chk("jk_term", term, 1'b0);

    // Out-of-range correction
    j = 4'b0000;
    k = 4'b0001;
    tick(1);
    chk("jk_load_c", q, 4'hC);
    mode = 2'b10;
    chk("oor_up_term", term, 1'b0);
    tick(1);
    chk("oor_up_q", q, 4'h0);
    chk("oor_up_wrap", wrap, 1'b0);
    mode = 2'b01;
    j    = 4'b1100;
    k    = 4'b0000;
    tick(1);
    chk("jk_reload_c", q, 4'hC);
    mode = 2'b11;
    tick(1);
    chk("oor_down_q", q, 4'h9);
    chk("oor_down_wrap", wrap, 1'b0);

    // Enable low holds everything; terminal ignores enable
    en   = 1'b0;
    mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("en0_q", q, 4'h9);
      chk("en0_term", term, 1'b1);
      chk("en0_wrap", wrap, 1'b0);
    end
    en = 1'b1;
    tick(1);
    chk("en1_q", q, 4'h0);
    chk("en1_wrap", wrap, 1'b1);

    // Enable low clears wrap; enabled hold mode keeps Q
    en = 1'b0;
    tick(1);
    chk("en0_wrap_clr", wrap, 1'b0);
    en   = 1'b1;
    mode = 2'b01;
    j    = 4'b0110;
    k    = 4'b0000;
    tick(1);
    chk("jk_load_6", q, 4'h6);
    mode = 2'b00;
    tick(2);
    chk("hold_q", q, 4'h6);
    chk("hold_term", term, 1'b0);
    chk("hold_wrap", wrap, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
